// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} fetch_state_e;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int          PC_INCR   = 4;
endpackage

// File: rtl/if_fetch_unit_skid.sv
// One-entry skid buffer holding {instr, pc_plus4} for a fetch acked while the
// decode stage is stalled.
module fetch_skid_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load,
  input  logic             drain,
  input  logic             flush,
  input  logic [WIDTH-1:0] instr_d,
  input  logic [WIDTH-1:0] pc4_d,
  output logic [WIDTH-1:0] instr_q,
  output logic [WIDTH-1:0] pc4_q,
  output logic             full
);
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      full    <= 1'b0;
      instr_q <= '0;
      pc4_q   <= '0;
    end else if (flush || drain) begin
      full <= 1'b0;
    end else if (load) begin
      full    <= 1'b1;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC, imem req/ack handshake, stall skid, redirect.
// Optional perf counters enabled by defining IF_FETCH_PERF_CNT_EN.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [WIDTH-1:0] redirect_pc_i,
  output logic             imem_req_o,
  output logic [WIDTH-1:0] imem_addr_o,
  input  logic             imem_ack_i,
  input  logic [WIDTH-1:0] imem_rdata_i,
  output logic [WIDTH-1:0] instr_if32,
  output logic [WIDTH-1:0] pc_plus4_if32,
  output logic             instr_valid_if
`ifdef IF_FETCH_PERF_CNT_EN
  ,
  output logic [31:0]      perf_fetched_o,
  output logic [31:0]      perf_bubble_o
`endif
);
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

  fetch_state_e     state, nxt_state;
  logic [WIDTH-1:0] pc_q, nxt_pc, redir_q, nxt_redir, pc_inc, redir_pc;
  logic             out_ld, out_vld;
  logic [WIDTH-1:0] out_instr, out_pc4;
  logic             skid_ld, skid_dr, skid_fl, skid_full;
  logic [WIDTH-1:0] skid_instr, skid_pc4;

  assign imem_req_o  = (state == FETCH) || (state == DISCARD);
  assign imem_addr_o = pc_q;
  assign pc_inc      = pc_q + WIDTH'(PC_INCR);
  assign redir_pc    = redirect_pc_i & ALIGN_MASK;

  fetch_skid_buf #(.WIDTH(WIDTH)) u_skid (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load    (skid_ld),
    .drain   (skid_dr),
    .flush   (skid_fl),
    .instr_d (imem_rdata_i),
    .pc4_d   (pc_inc),
    .instr_q (skid_instr),
    .pc4_q   (skid_pc4),
    .full    (skid_full)
  );

  always_comb begin
    nxt_state = state;
    nxt_pc    = pc_q;
    nxt_redir = redir_q;
    out_ld    = 1'b0;
    out_vld   = 1'b0;
    out_instr = WIDTH'(NOP_INSTR);
    out_pc4   = '0;
    skid_ld   = 1'b0;
    skid_dr   = 1'b0;
    skid_fl   = 1'b0;
    case (state)
      IDLE: nxt_state = FETCH;
      FETCH: begin
        if (imem_ack_i) begin
          if (redirect_i) begin
            nxt_pc = redir_pc;
            out_ld = 1'b1;
          end else if (!stall_i) begin
            nxt_pc    = pc_inc;
            out_ld    = 1'b1;
            out_vld   = 1'b1;
            out_instr = imem_rdata_i;
            out_pc4   = pc_inc;
          end else begin
            nxt_pc    = pc_inc;
            skid_ld   = 1'b1;
            nxt_state = HOLD;
          end
        end else if (redirect_i) begin
          // Keep pc_q so the in-flight address stays stable until its ack.
          nxt_redir = redir_pc;
          out_ld    = 1'b1;
          nxt_state = DISCARD;
        end else if (!stall_i) begin
          out_ld = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_i) begin
          skid_fl   = 1'b1;
          nxt_pc    = redir_pc;
          out_ld    = 1'b1;
          nxt_state = FETCH;
        end else if (!stall_i && skid_full) begin
          skid_dr   = 1'b1;
          out_ld    = 1'b1;
          out_vld   = 1'b1;
          out_instr = skid_instr;
          out_pc4   = skid_pc4;
          nxt_state = FETCH;
        end
      end
      DISCARD: begin
        if (imem_ack_i) begin
          nxt_pc    = redirect_i ? redir_pc : redir_q;
          nxt_state = FETCH;
        end else if (redirect_i) begin
          nxt_redir = redir_pc;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state          <= IDLE;
      pc_q           <= RESET_PC & ALIGN_MASK;
      redir_q        <= '0;
      instr_if32     <= WIDTH'(NOP_INSTR);
      pc_plus4_if32  <= '0;
      instr_valid_if <= 1'b0;
    end else begin
      state   <= nxt_state;
      pc_q    <= nxt_pc;
      redir_q <= nxt_redir;
      if (out_ld) begin
        instr_if32     <= out_instr;
        pc_plus4_if32  <= out_pc4;
        instr_valid_if <= out_vld;
      end
    end
  end

`ifdef IF_FETCH_PERF_CNT_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      perf_fetched_o <= '0;
      perf_bubble_o  <= '0;
    end else if (out_ld) begin
      if (out_vld) perf_fetched_o <= perf_fetched_o + 32'd1;
      else         perf_bubble_o  <= perf_bubble_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: latency-programmable imem model plus a
// second instance started at the top of the address space.
module tb_if_fetch_unit;
  logic        clk_i = 1'b0;
  logic        reset_i, stall_i, redirect_i;
  logic [31:0] redirect_pc_i;
  logic        req, ack, req2, ack2;
  logic [31:0] addr, rdata, addr2, rdata2;
  logic [31:0] instr, pc4, instr2, pc42;
  logic        vld, vld2;
  int          lat;
  int          cnt;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] memf(input logic [31:0] a);
    case (a)
      32'h0:   memf = 32'h2008_0005;
      32'h4:   memf = 32'h2009_0003;
      default: memf = {16'hC000, a[15:0]};
    endcase
  endfunction

  // ack fires once the request has been up for lat cycles
  always @(posedge clk_i or posedge reset_i)
    if (reset_i || !req || ack) cnt <= 0;
    else cnt <= cnt + 1;
  assign ack    = req && (cnt == lat);
  assign rdata  = memf(addr);
  assign ack2   = req2;
  assign rdata2 = memf(addr2);

  if_fetch_unit dut (
    .clk_i(clk_i), .reset_i(reset_i), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_req_o(req), .imem_addr_o(addr),
    .imem_ack_i(ack), .imem_rdata_i(rdata), .instr_if32(instr),
    .pc_plus4_if32(pc4), .instr_valid_if(vld));

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk_i(clk_i), .reset_i(reset_i), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_req_o(req2), .imem_addr_o(addr2),
    .imem_ack_i(ack2), .imem_rdata_i(rdata2), .instr_if32(instr2),
    .pc_plus4_if32(pc42), .instr_valid_if(vld2));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic out_is(input string tag, input logic [31:0] i, input logic [31:0] p, input logic v);
    chk({tag, ".instr"}, instr, i);
    chk({tag, ".pc4"},   pc4,   p);
    chk({tag, ".vld"},   {31'd0, vld}, {31'd0, v});
  endtask

  initial begin
    reset_i = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; lat = 0;
    tick(2);
    out_is("rst", 32'h0, 32'h0, 1'b0);
    chk("rst.req",  {31'd0, req}, 32'd0);
    chk("rst.addr", addr, 32'h0);
    chk("rst.addr2", addr2, 32'hFFFF_FFFC);
    reset_i = 1'b0;

    // zero-wait stream
    tick(1);
    chk("idle.req", {31'd0, req}, 32'd1);
    chk("idle.addr", addr, 32'h0);
    chk("idle.vld", {31'd0, vld}, 32'd0);
    tick(1);
    out_is("zw0", 32'h2008_0005, 32'h4, 1'b1);
    chk("zw0.addr", addr, 32'h4);
    chk("wrap.instr", instr2, 32'hC000_FFFC);
    chk("wrap.pc4", pc42, 32'h0);
    chk("wrap.vld", {31'd0, vld2}, 32'd1);
    chk("wrap.addr", addr2, 32'h0);
    tick(1);
    out_is("zw1", 32'h2009_0003, 32'h8, 1'b1);
    chk("zw1.addr", addr, 32'h8);
    chk("wrap2.pc4", pc42, 32'h4);

    // ack on the third cycle of each request
    lat = 2;
    tick(1);
    out_is("lat.b0", 32'h0, 32'h0, 1'b0);
    chk("lat.addr0", addr, 32'h8);
    tick(1);
    out_is("lat.b1", 32'h0, 32'h0, 1'b0);
    chk("lat.addr1", addr, 32'h8);
    tick(1);
    out_is("lat.v", 32'hC000_0008, 32'hC, 1'b1);
    chk("lat.addr2", addr, 32'hC);

    // ack while stalled goes to the skid
    lat = 0; stall_i = 1'b1;
    tick(1);
    chk("hold.req", {31'd0, req}, 32'd0);
    out_is("hold0", 32'hC000_0008, 32'hC, 1'b1);
    tick(1);
    out_is("hold1", 32'hC000_0008, 32'hC, 1'b1);
    stall_i = 1'b0;
    tick(1);
    out_is("skid", 32'hC000_000C, 32'h10, 1'b1);
    chk("skid.addr", addr, 32'h10);
    chk("skid.req", {31'd0, req}, 32'd1);
    tick(1);
    out_is("post", 32'hC000_0010, 32'h14, 1'b1);

    // redirect with request outstanding
    lat = 2; redirect_i = 1'b1; redirect_pc_i = 32'h0000_0043;
    tick(1);
    redirect_i = 1'b0;
    out_is("disc0", 32'h0, 32'h0, 1'b0);
    chk("disc0.addr", addr, 32'h14);
    chk("disc0.req", {31'd0, req}, 32'd1);
    tick(1);
    chk("disc1.addr", addr, 32'h14);
    chk("disc1.vld", {31'd0, vld}, 32'd0);
    tick(1);
    out_is("disc2", 32'h0, 32'h0, 1'b0);
    chk("disc2.addr", addr, 32'h40);
    tick(2);
    chk("disc3.vld", {31'd0, vld}, 32'd0);
    tick(1);
    out_is("tgt", 32'hC000_0040, 32'h44, 1'b1);

    // redirect beats stall; then redirect out of HOLD flushes the skid
    lat = 0; stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h100;
    tick(1);
    out_is("flush", 32'h0, 32'h0, 1'b0);
    chk("flush.addr", addr, 32'h100);
    redirect_i = 1'b0;
    tick(1);
    chk("hold2.req", {31'd0, req}, 32'd0);
    chk("hold2.vld", {31'd0, vld}, 32'd0);
    redirect_i = 1'b1; redirect_pc_i = 32'h200;
    tick(1);
    out_is("hflush", 32'h0, 32'h0, 1'b0);
    chk("hflush.addr", addr, 32'h200);
    chk("hflush.req", {31'd0, req}, 32'd1);
    redirect_i = 1'b0; stall_i = 1'b0;
    tick(1);
    out_is("hflush.v", 32'hC000_0200, 32'h204, 1'b1);

    // asynchronous reset mid-request
    #2 reset_i = 1'b1;
    #1;
    chk("areset.req", {31'd0, req}, 32'd0);
    out_is("areset", 32'h0, 32'h0, 1'b0);
    chk("areset.addr", addr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
